// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX issue register feeding the execute ALU
//
// Purpose: accepts one decoded instruction per cycle and resolves EX/MEM and
// MEM/WB operand forwarding at the input. It decodes the 4-bit ALU control and
// registers operands, control, rd and store data behind a valid/ready handshake.
// A flush kills the held entry and drops any instruction arriving with it.
//
// Optional feature macro: ALU_ISSUE_PERF_EN adds the parameter CNT_W and the
// saturating issue_count / stall_count output ports.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   in_valid / in_ready              decode-side handshake
//   rs1_data, rs2_data, imm          register-file reads, sign-extended immediate
//   rs1_addr, rs2_addr, rd_addr      source and destination indices
//   alu_src, alu_op, funct3, funct7_b5  ALU control decode inputs
//   exmem_reg_write/rd/result        EX/MEM forwarding source
//   memwb_reg_write/rd/result        MEM/WB forwarding source
//   flush                            kill held or arriving instruction
//   out_valid / out_ready            ALU-side handshake
//   first_operand, second_operand    registered ALU operands
//   alu_control                      registered ALU control code
//   out_rd, out_store_data           registered rd and forwarded rs2 value
//   decode_err                       unsupported funct3 under alu_op=10
//   issue_count, stall_count         performance counters (ALU_ISSUE_PERF_EN)

module alu_issue_stage #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
`ifdef ALU_ISSUE_PERF_EN
   ,
   parameter int CNT_W      = 16
`endif
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     rs1_data,
   input  logic [DATA_W-1:0]     rs2_data,
   input  logic [DATA_W-1:0]     imm,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic                  alu_src,
   input  logic [1:0]            alu_op,
   input  logic [2:0]            funct3,
   input  logic                  funct7_b5,
   input  logic                  exmem_reg_write,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic [DATA_W-1:0]     exmem_result,
   input  logic                  memwb_reg_write,
   input  logic [REG_ADDR_W-1:0] memwb_rd,
   input  logic [DATA_W-1:0]     memwb_result,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     first_operand,
   output logic [DATA_W-1:0]     second_operand,
   output logic [3:0]            alu_control,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic [DATA_W-1:0]     out_store_data,
   output logic                  decode_err
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [CNT_W-1:0]      issue_count,
   output logic [CNT_W-1:0]      stall_count
`endif
);

   localparam logic [3:0] CTL_AND = 4'b0000;
   localparam logic [3:0] CTL_OR  = 4'b0001;
   localparam logic [3:0] CTL_ADD = 4'b0010;
   localparam logic [3:0] CTL_SUB = 4'b0110;
   localparam logic [3:0] CTL_NOR = 4'b1100;

   logic                  valid_q, valid_d;
   logic [DATA_W-1:0]     op_a_q, op_a_d;
   logic [DATA_W-1:0]     op_b_q, op_b_d;
   logic [DATA_W-1:0]     store_q, store_d;
   logic [3:0]            ctl_q, ctl_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;
   logic                  err_q, err_d;

   logic                  load;
   logic [DATA_W-1:0]     fwd_rs1, fwd_rs2;
   logic [3:0]            ctl_dec;
   logic                  err_dec;

   assign in_ready = ~valid_q | out_ready | flush;
   // Flush wins over load: an instruction arriving with flush is accepted and dropped.
   assign load     = in_valid & in_ready & ~flush;

   // EX/MEM is the younger producer, so it takes priority; x0 is never forwarded.
   always_comb begin
      fwd_rs1 = rs1_data;
      if (exmem_reg_write && (exmem_rd == rs1_addr) && (rs1_addr != '0))
         fwd_rs1 = exmem_result;
      else if (memwb_reg_write && (memwb_rd == rs1_addr) && (rs1_addr != '0))
         fwd_rs1 = memwb_result;
   end

   always_comb begin
      fwd_rs2 = rs2_data;
      if (exmem_reg_write && (exmem_rd == rs2_addr) && (rs2_addr != '0))
         fwd_rs2 = exmem_result;
      else if (memwb_reg_write && (memwb_rd == rs2_addr) && (rs2_addr != '0))
         fwd_rs2 = memwb_result;
   end

   // funct7 bit 30 only means SUB for register-register forms; ADDI may carry it set.
   always_comb begin
      ctl_dec = CTL_ADD;
      err_dec = 1'b0;
      unique case (alu_op)
         2'b00: ctl_dec = CTL_ADD;
         2'b01: ctl_dec = CTL_SUB;
         2'b11: ctl_dec = CTL_NOR;
         2'b10: begin
            unique case (funct3)
               3'b000:  ctl_dec = (funct7_b5 & ~alu_src) ? CTL_SUB : CTL_ADD;
               3'b111:  ctl_dec = CTL_AND;
               3'b110:  ctl_dec = CTL_OR;
               default: begin
                  ctl_dec = CTL_ADD;
                  err_dec = 1'b1;
               end
            endcase
         end
         default: ctl_dec = CTL_ADD;
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      store_d = store_q;
      ctl_d   = ctl_q;
      rd_d    = rd_q;
      err_d   = err_q;
      if (flush)
         valid_d = 1'b0;
      else if (load)
         valid_d = 1'b1;
      else if (out_ready)
         valid_d = 1'b0;
      // Data registers only change on load, so a drained entry keeps its values.
      if (load) begin
         op_a_d  = fwd_rs1;
         op_b_d  = alu_src ? imm : fwd_rs2;
         store_d = fwd_rs2;
         ctl_d   = ctl_dec;
         rd_d    = rd_addr;
         err_d   = err_dec;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         store_q <= '0;
         ctl_q   <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         store_q <= store_d;
         ctl_q   <= ctl_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
      end
   end

   assign out_valid      = valid_q;
   assign first_operand  = op_a_q;
   assign second_operand = op_b_q;
   assign alu_control    = ctl_q;
   assign out_rd         = rd_q;
   assign out_store_data = store_q;
   // The error flag belongs to the held entry; hide it once that entry drains.
   assign decode_err     = err_q & valid_q;

`ifdef ALU_ISSUE_PERF_EN
   logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      issue_cnt_d = issue_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (flush) begin
         issue_cnt_d = '0;
         stall_cnt_d = '0;
      end else begin
         if (valid_q && out_ready && (issue_cnt_q != '1))
            issue_cnt_d = issue_cnt_q + 1'b1;
         if (valid_q && !out_ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign issue_count = issue_cnt_q;
   assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;

   typedef struct {
      logic [31:0] fo;
      logic [31:0] so;
      logic [31:0] sd;
      logic [3:0]  ctl;
      logic [4:0]  rd;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] rs1_data = '0, rs2_data = '0, imm = '0;
   logic [4:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
   logic        alu_src = 1'b0;
   logic [1:0]  alu_op = '0;
   logic [2:0]  funct3 = '0;
   logic        funct7_b5 = 1'b0;
   logic        exmem_reg_write = 1'b0;
   logic [4:0]  exmem_rd = '0;
   logic [31:0] exmem_result = '0;
   logic        memwb_reg_write = 1'b0;
   logic [4:0]  memwb_rd = '0;
   logic [31:0] memwb_result = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] first_operand, second_operand, out_store_data;
   logic [3:0]  alu_control;
   logic [4:0]  out_rd;
   logic        decode_err;
`ifdef ALU_ISSUE_PERF_EN
   logic [15:0] issue_count, stall_count;
`endif

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];
   exp_t e;

   alu_issue_stage dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .alu_src(alu_src), .alu_op(alu_op), .funct3(funct3), .funct7_b5(funct7_b5),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .first_operand(first_operand), .second_operand(second_operand),
      .alu_control(alu_control), .out_rd(out_rd), .out_store_data(out_store_data),
      .decode_err(decode_err)
`ifdef ALU_ISSUE_PERF_EN
      , .issue_count(issue_count), .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every consumed output must match the oldest expected entry.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
         end else begin
            exp_t x;
            x = sb.pop_front();
            chk("first_operand", first_operand, x.fo);
            chk("second_operand", second_operand, x.so);
            chk("store_data", out_store_data, x.sd);
            chk("alu_control", {28'd0, alu_control}, {28'd0, x.ctl});
            chk("out_rd", {27'd0, out_rd}, {27'd0, x.rd});
            chk("decode_err", {31'd0, decode_err}, {31'd0, x.err});
         end
      end
   end

   task automatic set_in(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic src, input logic [4:0] r1a, input logic [31:0] r1d,
                         input logic [4:0] r2a, input logic [31:0] r2d,
                         input logic [31:0] im, input logic [4:0] rda);
      alu_op = op; funct3 = f3; funct7_b5 = f7; alu_src = src;
      rs1_addr = r1a; rs1_data = r1d; rs2_addr = r2a; rs2_data = r2d;
      imm = im; rd_addr = rda;
   endtask

   task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                          input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
      exmem_reg_write = ew; exmem_rd = erd; exmem_result = eres;
      memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mres;
   endtask

   // Presents the already-driven inputs until accepted; expectation recorded on accept.
   task automatic send(input exp_t x);
      int n;
      n = 0;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
      else sb.push_back(x);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_queue_empty", sb.size(), 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_first_operand", first_operand, 32'd0);
      chk("reset_alu_control", {28'd0, alu_control}, 32'd0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

      // R-type SUB, no forwarding
      set_in(2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 32'd9, 5'd2, 32'd4, 32'd0, 5'd3);
      e = '{fo: 32'd9, so: 32'd4, sd: 32'd4, ctl: 4'b0110, rd: 5'd3, err: 1'b0};
      send(e);
      #1 chk("sub_out_valid", {31'd0, out_valid}, 32'd1);

      // Both stages match rs1: EX/MEM wins
      set_fwd(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
      set_in(2'b00, 3'b000, 1'b0, 1'b0, 5'd5, 32'h99, 5'd6, 32'd7, 32'd0, 5'd4);
      e = '{fo: 32'h11, so: 32'd7, sd: 32'd7, ctl: 4'b0010, rd: 5'd4, err: 1'b0};
      send(e);

      // x0 is never forwarded
      set_fwd(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
      set_in(2'b00, 3'b000, 1'b0, 1'b0, 5'd0, 32'h99, 5'd6, 32'd7, 32'd0, 5'd4);
      e = '{fo: 32'h99, so: 32'd7, sd: 32'd7, ctl: 4'b0010, rd: 5'd4, err: 1'b0};
      send(e);

      // MEM/WB-only match on rs2, EX/MEM targets another register
      set_fwd(1'b1, 5'd7, 32'h11, 1'b1, 5'd6, 32'h22);
      set_in(2'b01, 3'b000, 1'b0, 1'b0, 5'd1, 32'h50, 5'd6, 32'd7, 32'd0, 5'd8);
      e = '{fo: 32'h50, so: 32'h22, sd: 32'h22, ctl: 4'b0110, rd: 5'd8, err: 1'b0};
      send(e);

      // Address match but no write enables: NOR with register-file data
      set_fwd(1'b0, 5'd1, 32'h11, 1'b0, 5'd2, 32'h22);
      set_in(2'b11, 3'b000, 1'b0, 1'b0, 5'd1, 32'hA, 5'd2, 32'hB, 32'd0, 5'd9);
      e = '{fo: 32'hA, so: 32'hB, sd: 32'hB, ctl: 4'b1100, rd: 5'd9, err: 1'b0};
      send(e);

      // AND / OR decode
      set_in(2'b10, 3'b111, 1'b0, 1'b0, 5'd1, 32'd3, 5'd2, 32'd5, 32'd0, 5'd10);
      e = '{fo: 32'd3, so: 32'd5, sd: 32'd5, ctl: 4'b0000, rd: 5'd10, err: 1'b0};
      send(e);
      set_in(2'b10, 3'b110, 1'b0, 1'b0, 5'd1, 32'd3, 5'd2, 32'd5, 32'd0, 5'd11);
      e = '{fo: 32'd3, so: 32'd5, sd: 32'd5, ctl: 4'b0001, rd: 5'd11, err: 1'b0};
      send(e);

      // ADDI with bit 30 set stays ADD, operand B is the immediate
      set_in(2'b10, 3'b000, 1'b1, 1'b1, 5'd1, 32'd10, 5'd2, 32'h77, 32'hFFFF_FFFD, 5'd12);
      e = '{fo: 32'd10, so: 32'hFFFF_FFFD, sd: 32'h77, ctl: 4'b0010, rd: 5'd12, err: 1'b0};
      send(e);

      // Unsupported funct3 under alu_op=10
      set_in(2'b10, 3'b100, 1'b0, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd13);
      e = '{fo: 32'd1, so: 32'd2, sd: 32'd2, ctl: 4'b0010, rd: 5'd13, err: 1'b1};
      send(e);
      drain();
      chk("drained_out_valid", {31'd0, out_valid}, 32'd0);

      // Backpressure: held entry frozen for 3 cycles, next loads when ready returns
      out_ready = 1'b0;
      set_in(2'b00, 3'b000, 1'b0, 1'b0, 5'd1, 32'h100, 5'd2, 32'h200, 32'd0, 5'd9);
      e = '{fo: 32'h100, so: 32'h200, sd: 32'h200, ctl: 4'b0010, rd: 5'd9, err: 1'b0};
      send(e);
      set_in(2'b01, 3'b000, 1'b0, 1'b0, 5'd1, 32'h300, 5'd2, 32'h40, 32'd0, 5'd10);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_first_operand", first_operand, 32'h100);
         chk("hold_second_operand", second_operand, 32'h200);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      e = '{fo: 32'h300, so: 32'h40, sd: 32'h40, ctl: 4'b0110, rd: 5'd10, err: 1'b0};
      send(e);
      drain();

      // Flush collision: held entry killed, simultaneous input dropped
      out_ready = 1'b0;
      set_in(2'b00, 3'b000, 1'b0, 1'b0, 5'd1, 32'h55, 5'd2, 32'h66, 32'd0, 5'd14);
      e = '{fo: 32'h55, so: 32'h66, sd: 32'h66, ctl: 4'b0010, rd: 5'd14, err: 1'b0};
      send(e);
      set_in(2'b10, 3'b111, 1'b0, 1'b0, 5'd1, 32'h77, 5'd2, 32'h88, 32'd0, 5'd15);
      flush = 1'b1;
      in_valid = 1'b1;
      void'(sb.pop_back());
      #1 chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("after_flush_out_valid", {31'd0, out_valid}, 32'd0);

      // Async reset while an entry (with decode_err set) is held
      out_ready = 1'b0;
      set_in(2'b10, 3'b101, 1'b0, 1'b0, 5'd1, 32'h12, 5'd2, 32'h34, 32'd0, 5'd16);
      e = '{fo: 32'h12, so: 32'h34, sd: 32'h34, ctl: 4'b0010, rd: 5'd16, err: 1'b1};
      send(e);
      chk("pre_reset_decode_err", {31'd0, decode_err}, 32'd1);
      #2 reset_n = 1'b0;
      void'(sb.pop_back());
      #1;
      chk("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_reset_first_operand", first_operand, 32'd0);
      chk("async_reset_second_operand", second_operand, 32'd0);
      chk("async_reset_store_data", out_store_data, 32'd0);
      chk("async_reset_alu_control", {28'd0, alu_control}, 32'd0);
      chk("async_reset_out_rd", {27'd0, out_rd}, 32'd0);
      chk("async_reset_decode_err", {31'd0, decode_err}, 32'd0);
      @(negedge clk) reset_n = 1'b1;
      #1 chk("release_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
